// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller uses the master modport; the datapath uses the slave modport.
interface mips_multicycle_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       ExtOp;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               ALUControl, PCSrc, PCEn, ExtOp, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
               ALUControl, PCSrc, PCEn, ExtOp, State
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style main controller for the multicycle MIPS datapath, with a wait
// counter that stretches the memory-access states (FETCH, MEMRD, MEMWR).
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StAluWb  = 4'd7,
        StBeq    = 4'd8,
        StImmEx  = 4'd9,
        StImmWb  = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       wait_done;
    logic       pcwrite, branch, irwrite, memwrite, regwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        irwrite        = 1'b0;
        memwrite       = 1'b0;
        regwrite       = 1'b0;
        bus.IorD       = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = AluAdd;
        bus.PCSrc      = 2'b00;
        bus.ExtOp      = 1'b0;
        wait_done      = (wait_q == WaitLast);

        case (state_q)
            StFetch: begin
                bus.ALUSrcB = 2'b01;
                if (wait_done) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                bus.ALUSrcB = 2'b11;
                bus.ExtOp   = 1'b1;
                case (bus.Op)
                    OpLw, OpSw:                     state_d = StMemAdr;
                    OpRtype:                        state_d = StExecR;
                    OpBeq:                          state_d = StBeq;
                    OpAddi, OpSlti, OpAndi, OpOri:  state_d = StImmEx;
                    OpJ:                            state_d = StJump;
                    default:                        state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = 1'b1;
                state_d     = (bus.Op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                bus.IorD = 1'b1;
                if (wait_done) state_d = StMemWb;
            end
            StMemWb: begin
                bus.MemtoReg = 1'b1;
                regwrite     = 1'b1;
                state_d      = StFetch;
            end
            StMemWr: begin
                bus.IorD = 1'b1;
                if (wait_done) begin
                    memwrite = 1'b1;
                    state_d  = StFetch;
                end
            end
            StExecR: begin
                bus.ALUSrcA = 1'b1;
                case (bus.Funct)
                    6'b100000: bus.ALUControl = AluAdd;
                    6'b100010: bus.ALUControl = AluSub;
                    6'b100100: bus.ALUControl = AluAnd;
                    6'b100101: bus.ALUControl = AluOr;
                    6'b101010: bus.ALUControl = AluSlt;
                    default:   bus.ALUControl = AluAdd;
                endcase
                state_d = StAluWb;
            end
            StAluWb: begin
                bus.RegDst = 1'b1;
                regwrite   = 1'b1;
                state_d    = StFetch;
            end
            StBeq: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = AluSub;
                bus.PCSrc      = 2'b01;
                branch         = 1'b1;
                state_d        = StFetch;
            end
            StImmEx: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (bus.Op)
                    OpSlti:  begin bus.ALUControl = AluSlt; bus.ExtOp = 1'b1; end
                    OpAndi:  begin bus.ALUControl = AluAnd; bus.ExtOp = 1'b0; end
                    OpOri:   begin bus.ALUControl = AluOr;  bus.ExtOp = 1'b0; end
                    default: begin bus.ALUControl = AluAdd; bus.ExtOp = 1'b1; end
                endcase
                state_d = StImmWb;
            end
            StImmWb: begin
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StJump: begin
                bus.PCSrc = 2'b10;
                pcwrite   = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Every state change clears the counter, so entry into a wait state starts at 0.
        wait_d = (state_d != state_q) ? 4'd0 : wait_q + 4'd1;
    end

    // Write enables are gated by rst_n so nothing is written while reset is held.
    assign bus.IRWrite  = irwrite & rst_n;
    assign bus.MemWrite = memwrite & rst_n;
    assign bus.RegWrite = regwrite & rst_n;
    assign bus.PCEn     = (pcwrite | (branch & bus.Zero)) & rst_n;
    assign bus.State    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance with no memory wait,
// one with a two-cycle wait, checked on the falling clock edge.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if b0 ();
    mips_multicycle_ctrl_if b2 ();

    mips_multicycle_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    mips_multicycle_ctrl #(.MEM_WAIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.master));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        b0.Op = op;  b0.Funct = funct;  b0.Zero = zero;
        b2.Op = op;  b2.Funct = funct;  b2.Zero = zero;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reset held over two edges, released on a falling edge: both DUTs sit in FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", {4'd0, b0.State}, 8'd0);
        chk("rst_irwrite", {7'd0, b0.IRWrite}, 8'd0);
        chk("rst_pcen", {7'd0, b0.PCEn}, 8'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        set_in(6'b100011, 6'd0, 1'b0);
        step();

        // lw, no wait: 0,1,2,3,4,0
        do_reset();
        #1;
        chk("lw_f_state", {4'd0, b0.State}, 8'd0);
        chk("lw_f_irwrite", {7'd0, b0.IRWrite}, 8'd1);
        chk("lw_f_pcen", {7'd0, b0.PCEn}, 8'd1);
        step();
        chk("lw_d_state", {4'd0, b0.State}, 8'd1);
        chk("lw_d_irwrite", {7'd0, b0.IRWrite}, 8'd0);
        chk("lw_d_pcen", {7'd0, b0.PCEn}, 8'd0);
        step();
        chk("lw_ma_state", {4'd0, b0.State}, 8'd2);
        step();
        chk("lw_mr_state", {4'd0, b0.State}, 8'd3);
        chk("lw_mr_iord", {7'd0, b0.IorD}, 8'd1);
        chk("lw_mr_regwrite", {7'd0, b0.RegWrite}, 8'd0);
        step();
        chk("lw_wb_state", {4'd0, b0.State}, 8'd4);
        chk("lw_wb_regwrite", {7'd0, b0.RegWrite}, 8'd1);
        chk("lw_wb_memtoreg", {7'd0, b0.MemtoReg}, 8'd1);
        step();
        chk("lw_end_state", {4'd0, b0.State}, 8'd0);

        // sw on the MEM_WAIT=2 instance
        set_in(6'b101011, 6'd0, 1'b0);
        do_reset();
        #1;
        chk("sw_f0_state", {4'd0, b2.State}, 8'd0);
        chk("sw_f0_irwrite", {7'd0, b2.IRWrite}, 8'd0);
        step();
        chk("sw_f1_state", {4'd0, b2.State}, 8'd0);
        chk("sw_f1_irwrite", {7'd0, b2.IRWrite}, 8'd0);
        step();
        chk("sw_f2_state", {4'd0, b2.State}, 8'd0);
        chk("sw_f2_irwrite", {7'd0, b2.IRWrite}, 8'd1);
        chk("sw_f2_pcen", {7'd0, b2.PCEn}, 8'd1);
        step();
        chk("sw_d_state", {4'd0, b2.State}, 8'd1);
        step();
        chk("sw_ma_state", {4'd0, b2.State}, 8'd2);
        step();
        chk("sw_w0_state", {4'd0, b2.State}, 8'd5);
        chk("sw_w0_memwrite", {7'd0, b2.MemWrite}, 8'd0);
        chk("sw_w0_iord", {7'd0, b2.IorD}, 8'd1);
        step();
        chk("sw_w1_state", {4'd0, b2.State}, 8'd5);
        chk("sw_w1_memwrite", {7'd0, b2.MemWrite}, 8'd0);
        step();
        chk("sw_w2_state", {4'd0, b2.State}, 8'd5);
        chk("sw_w2_memwrite", {7'd0, b2.MemWrite}, 8'd1);
        step();
        chk("sw_end_state", {4'd0, b2.State}, 8'd0);
        chk("sw_end_memwrite", {7'd0, b2.MemWrite}, 8'd0);

        // R-type sub then slt, MEM_WAIT=0 instance
        set_in(6'b000000, 6'b100010, 1'b0);
        do_reset();
        step();
        chk("sub_d_state", {4'd0, b0.State}, 8'd1);
        step();
        chk("sub_ex_state", {4'd0, b0.State}, 8'd6);
        chk("sub_ex_alu", {5'd0, b0.ALUControl}, 8'b110);
        chk("sub_ex_srca", {7'd0, b0.ALUSrcA}, 8'd1);
        chk("sub_ex_srcb", {6'd0, b0.ALUSrcB}, 8'd0);
        step();
        chk("sub_wb_state", {4'd0, b0.State}, 8'd7);
        chk("sub_wb_regdst", {7'd0, b0.RegDst}, 8'd1);
        chk("sub_wb_regwrite", {7'd0, b0.RegWrite}, 8'd1);
        step();
        chk("sub_end_state", {4'd0, b0.State}, 8'd0);
        set_in(6'b000000, 6'b101010, 1'b0);
        step();
        step();
        chk("slt_ex_alu", {5'd0, b0.ALUControl}, 8'b111);
        step();
        chk("slt_wb_state", {4'd0, b0.State}, 8'd7);
        step();
        chk("slt_end_state", {4'd0, b0.State}, 8'd0);

        // beq taken then not taken
        set_in(6'b000100, 6'd0, 1'b1);
        step();
        step();
        chk("beq_state", {4'd0, b0.State}, 8'd8);
        chk("beq_pcsrc", {6'd0, b0.PCSrc}, 8'b01);
        chk("beq_alu", {5'd0, b0.ALUControl}, 8'b110);
        chk("beq_z1_pcen", {7'd0, b0.PCEn}, 8'd1);
        set_in(6'b000100, 6'd0, 1'b0);
        #1;
        chk("beq_z0_pcen", {7'd0, b0.PCEn}, 8'd0);
        step();
        chk("beq_end_state", {4'd0, b0.State}, 8'd0);

        // ori then addi
        set_in(6'b001101, 6'd0, 1'b0);
        step();
        step();
        chk("ori_ex_state", {4'd0, b0.State}, 8'd9);
        chk("ori_ex_extop", {7'd0, b0.ExtOp}, 8'd0);
        chk("ori_ex_alu", {5'd0, b0.ALUControl}, 8'b001);
        step();
        chk("ori_wb_state", {4'd0, b0.State}, 8'd10);
        chk("ori_wb_regdst", {7'd0, b0.RegDst}, 8'd0);
        chk("ori_wb_regwrite", {7'd0, b0.RegWrite}, 8'd1);
        step();
        set_in(6'b001000, 6'd0, 1'b0);
        step();
        step();
        chk("addi_ex_extop", {7'd0, b0.ExtOp}, 8'd1);
        chk("addi_ex_alu", {5'd0, b0.ALUControl}, 8'b010);
        step();
        chk("addi_wb_state", {4'd0, b0.State}, 8'd10);
        step();
        chk("addi_end_state", {4'd0, b0.State}, 8'd0);

        // j
        set_in(6'b000010, 6'd0, 1'b0);
        step();
        step();
        chk("j_state", {4'd0, b0.State}, 8'd11);
        chk("j_pcsrc", {6'd0, b0.PCSrc}, 8'b10);
        chk("j_pcen", {7'd0, b0.PCEn}, 8'd1);
        step();
        chk("j_end_state", {4'd0, b0.State}, 8'd0);

        // undefined opcode: DECODE straight back to FETCH, no writes
        set_in(6'b111111, 6'd0, 1'b0);
        step();
        chk("undef_d_state", {4'd0, b0.State}, 8'd1);
        chk("undef_d_writes",
            {4'd0, b0.RegWrite, b0.MemWrite, b0.IRWrite, b0.PCEn}, 8'd0);
        step();
        chk("undef_end_state", {4'd0, b0.State}, 8'd0);

        // reset asserted during MEMWB takes effect without a clock edge
        set_in(6'b100011, 6'd0, 1'b0);
        step();
        step();
        step();
        step();
        chk("rmid_wb_state", {4'd0, b0.State}, 8'd4);
        chk("rmid_wb_regwrite", {7'd0, b0.RegWrite}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_state", {4'd0, b0.State}, 8'd0);
        chk("rmid_regwrite", {7'd0, b0.RegWrite}, 8'd0);
        step();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
